// File: rtl/alarm_sequencer.sv
// Alarm ringing controller: arms on alarm_en, rings on the rising time match, handles stop/snooze/timeout.
// Optional feature macro: ALARM_BEEP_PATTERN_EN (1 s on / 1 s off beep instead of a steady tone).
module alarm_sequencer #(
   parameter int RING_TIMEOUT = 60,
   parameter int SNOOZE_SEC   = 300,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       alarm_en,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [5:0] amin,
   input  logic [5:0] asec,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       armed_led,
   output logic       ring_led,
   output logic       snooze_led,
   output logic       alarm_sound,
   output logic [3:0] snooze_left
);

   typedef enum logic [1:0] {IDLE, ARMED, RING, SNOOZE} state_t;

   localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT - 1);
   localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_SEC - 1);
   localparam logic [3:0]  MAX_SNZ   = 4'(MAX_SNOOZE);

   state_t      state, state_n;
   logic [15:0] ring_cnt, ring_cnt_n;
   logic [15:0] snz_cnt, snz_cnt_n;
   logic [3:0]  snooze_used, snooze_used_n;
   logic        match_d, snooze_d, stop_d;
   logic        ring_tick;

   logic match, match_rise, snooze_rise, stop_rise;
   assign match       = (min == amin) && (sec == asec);
   assign match_rise  = match & ~match_d;
   assign snooze_rise = snooze_btn & ~snooze_d;
   assign stop_rise   = stop_btn & ~stop_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ring_cnt    <= '0;
         snz_cnt     <= '0;
         snooze_used <= '0;
         match_d     <= 1'b0;
         snooze_d    <= 1'b0;
         stop_d      <= 1'b0;
      end else begin
         state       <= state_n;
         ring_cnt    <= ring_cnt_n;
         snz_cnt     <= snz_cnt_n;
         snooze_used <= snooze_used_n;
         match_d     <= match;
         snooze_d    <= snooze_btn;
         stop_d      <= stop_btn;
      end
   end

   // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_n       = state;
      ring_cnt_n    = ring_cnt;
      snz_cnt_n     = snz_cnt;
      snooze_used_n = snooze_used;
      ring_tick     = 1'b0;

      if (!alarm_en) begin
         state_n       = IDLE;
         snooze_used_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n       = ARMED;
               snooze_used_n = '0;
            end
            ARMED: begin
               if (match_rise) begin
                  state_n    = RING;
                  ring_cnt_n = '0;
               end
            end
            RING: begin
               if (stop_rise) begin
                  state_n       = ARMED;
                  snooze_used_n = '0;
               end else if (snooze_rise && (snooze_used < MAX_SNZ)) begin
                  state_n       = SNOOZE;
                  snooze_used_n = snooze_used + 4'd1;
                  snz_cnt_n     = '0;
               end else if (tick) begin
                  if (ring_cnt == RING_LAST) begin
                     state_n       = ARMED;
                     snooze_used_n = '0;
                  end else begin
                     ring_cnt_n = ring_cnt + 16'd1;
                     ring_tick  = 1'b1;
                  end
               end
            end
            SNOOZE: begin
               // Snooze presses and match edges are deliberately ignored while snoozing.
               if (stop_rise) begin
                  state_n       = ARMED;
                  snooze_used_n = '0;
               end else if (tick) begin
                  if (snz_cnt == SNZ_LAST) begin
                     state_n    = RING;
                     ring_cnt_n = '0;
                  end else begin
                     snz_cnt_n = snz_cnt + 16'd1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign armed_led   = (state != IDLE);
   assign ring_led    = (state == RING);
   assign snooze_led  = (state == SNOOZE);
   assign snooze_left = MAX_SNZ - snooze_used;

`ifdef ALARM_BEEP_PATTERN_EN
   logic beep, beep_n;

   always_comb begin
      beep_n = beep;
      if (state_n == RING && state != RING) beep_n = 1'b1;
      else if (ring_tick)                   beep_n = ~beep;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) beep <= 1'b0;
      else        beep <= beep_n;
   end

   assign alarm_sound = ring_led & beep;
`else
   assign alarm_sound = ring_led;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer with RING_TIMEOUT=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
module tb_alarm_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       alarm_en = 1'b0;
   logic [5:0] min = 6'd7, sec = 6'd0, amin = 6'd7, asec = 6'd30;
   logic       snooze_btn = 1'b0, stop_btn = 1'b0;
   logic       armed_led, ring_led, snooze_led, alarm_sound;
   logic [3:0] snooze_left;

   int n_checks = 0;
   int n_pass   = 0;

   alarm_sequencer #(.RING_TIMEOUT(4), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (
      .clk(clk), .reset(reset), .tick(tick), .alarm_en(alarm_en),
      .min(min), .sec(sec), .amin(amin), .asec(asec),
      .snooze_btn(snooze_btn), .stop_btn(stop_btn),
      .armed_led(armed_led), .ring_led(ring_led), .snooze_led(snooze_led),
      .alarm_sound(alarm_sound), .snooze_left(snooze_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic check_outs(input string tag, input logic a, input logic r, input logic s,
                             input logic snd, input logic [3:0] left);
      check({tag, ".armed"}, 32'(armed_led), 32'(a));
      check({tag, ".ring"}, 32'(ring_led), 32'(r));
      check({tag, ".snooze"}, 32'(snooze_led), 32'(s));
      check({tag, ".sound"}, 32'(alarm_sound), 32'(snd));
      check({tag, ".left"}, 32'(snooze_left), 32'(left));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic rematch();
      sec = 6'd31;
      step();
      sec = 6'd30;
      step();
   endtask

   task automatic press_snooze();
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
   endtask

   initial begin
      #22;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      @(negedge clk);
      reset = 1'b1;
      step();
      check_outs("idle_no_en", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

      alarm_en = 1'b1;
      step();
      check_outs("armed", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);

      // 07:30 reached
      sec = 6'd30;
      step();
      check_outs("ring_0730", 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);

`ifdef ALARM_BEEP_PATTERN_EN
      do_tick();
      check("beep_t1", 32'(alarm_sound), 32'd0);
      do_tick();
      check("beep_t2", 32'(alarm_sound), 32'd1);
      do_tick();
      check("beep_t3", 32'(alarm_sound), 32'd0);
`else
      do_tick();
      check("steady_t1", 32'(alarm_sound), 32'd1);
      do_tick();
      do_tick();
`endif
      check("ring_after3", 32'(ring_led), 32'd1);
      do_tick();
      check_outs("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      repeat (4) step();
      check("held_match_no_rering", 32'(ring_led), 32'd0);

      // Snooze sequence
      rematch();
      check_outs("ring2", 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
      press_snooze();
      check_outs("snooze1", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      step();
      do_tick();
      do_tick();
      check("snooze1_after2", 32'(snooze_led), 32'd1);
      do_tick();
      check_outs("reringing1", 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);

      press_snooze();
      check_outs("snooze2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      step();
      do_tick();
      do_tick();
      check("snooze2_after2", 32'(snooze_led), 32'd1);
      do_tick();
      check_outs("reringing2", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

      press_snooze();
      check_outs("snooze3_ignored", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
      step();

      // stop + snooze + tick in one cycle: stop wins
      stop_btn = 1'b1;
      snooze_btn = 1'b1;
      tick = 1'b1;
      step();
      stop_btn = 1'b0;
      snooze_btn = 1'b0;
      tick = 1'b0;
      check_outs("stop_wins", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      step();

      // alarm_en drop during SNOOZE
      rematch();
      check("ring3", 32'(ring_led), 32'd1);
      press_snooze();
      check_outs("snooze4", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      alarm_en = 1'b0;
      step();
      check_outs("en_drop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      alarm_en = 1'b1;
      step();
      check_outs("rearm", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      repeat (3) step();
      check("rearm_no_ring", 32'(ring_led), 32'd0);

      // Async reset mid-RING
      rematch();
      check("ring4", 32'(alarm_sound), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_sound", 32'(alarm_sound), 32'd0);
      check("async_reset_ring", 32'(ring_led), 32'd0);
      check("async_reset_left", 32'(snooze_left), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
